// File: rtl/silly_mask_sequencer.sv
// silly_mask_sequencer
//
// Drives the 8-bit AND-mask applied to the divided-clock taps. It replaces the
// static ui_in-to-mask path with a timed, looping pattern taken from a DEPTH-entry
// table of {mask, dwell} pairs. Entry k is held on mask_out for dwell[k]+1 clocks
// and then the next entry follows with no bubble cycle. After entry DEPTH-1 the
// sequence returns to entry 0. The table can only be loaded while the sequencer
// is idle, so the pattern in use cannot change halfway through a run.
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset (also clears the table)
//   ui_in     config data: the mask value, or the dwell value (low DWELL_W bits)
//   cfg_we    table write strobe; honoured only in IDLE
//   cfg_addr  table entry to write
//   cfg_sel   0 = write mask[cfg_addr], 1 = write dwell[cfg_addr]
//   run       level; 1 = sequence, 0 = idle
//   mask_out  current mask to the AND stage (registered)
//   step_idx  index of the entry currently on mask_out (registered)
//   busy      high while sequencing
//   seq_wrap  one-cycle pulse when entry 0 is re-entered by wrap-around
//
// State table:
//   state | meaning
//   IDLE  | outputs parked at zero; table writable; waits for run=1
//   RUN   | stepping through the table; table write-protected

module silly_mask_sequencer #(
  parameter int DEPTH   = 4,
  parameter int DWELL_W = 8,
  localparam int IW     = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    ui_in,
  input  logic          cfg_we,
  input  logic [IW-1:0] cfg_addr,
  input  logic          cfg_sel,
  input  logic          run,
  output logic [7:0]    mask_out,
  output logic [IW-1:0] step_idx,
  output logic          busy,
  output logic          seq_wrap
);

  // Number of ui_in bits that reach a dwell entry; wider counters are zero-extended.
  localparam int UW = (DWELL_W < 8) ? DWELL_W : 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [7:0]         mask_tbl  [DEPTH];
  logic [DWELL_W-1:0] dwell_tbl [DEPTH];

  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] cnt_nxt;
  logic [7:0]         mask_nxt;
  logic [IW-1:0]      idx_nxt;
  logic               busy_nxt;
  logic               wrap_nxt;

  logic [IW-1:0]      adv_idx;
  logic               tbl_we;
  logic [DWELL_W-1:0] dwell_wdata;

  // DEPTH is a power of two, so the natural overflow of the adder gives the
  // wrap from DEPTH-1 back to 0.
  assign adv_idx     = step_idx + IW'(1);
  assign tbl_we      = (state == IDLE) && cfg_we;
  assign dwell_wdata = DWELL_W'(ui_in[UW-1:0]);

  always_comb begin
    state_nxt = state;
    mask_nxt  = mask_out;
    idx_nxt   = step_idx;
    cnt_nxt   = cnt;
    busy_nxt  = busy;
    wrap_nxt  = 1'b0;

    case (state)
      IDLE: begin
        mask_nxt = 8'h00;
        idx_nxt  = '0;
        busy_nxt = 1'b0;
        if (run) begin
          state_nxt = RUN;
          mask_nxt  = mask_tbl[0];
          idx_nxt   = '0;
          cnt_nxt   = dwell_tbl[0];
          busy_nxt  = 1'b1;
        end
      end

      RUN: begin
        // Dropping run wins over an advance that falls due on the same edge,
        // so a stop never produces a wrap pulse.
        if (!run) begin
          state_nxt = IDLE;
          mask_nxt  = 8'h00;
          idx_nxt   = '0;
          busy_nxt  = 1'b0;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - DWELL_W'(1);
        end else begin
          mask_nxt = mask_tbl[adv_idx];
          idx_nxt  = adv_idx;
          cnt_nxt  = dwell_tbl[adv_idx];
          wrap_nxt = (adv_idx == '0);
        end
      end

      default: begin
        state_nxt = IDLE;
        mask_nxt  = 8'h00;
        idx_nxt   = '0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mask_out <= 8'h00;
      step_idx <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      seq_wrap <= 1'b0;
    end else begin
      state    <= state_nxt;
      mask_out <= mask_nxt;
      step_idx <= idx_nxt;
      cnt      <= cnt_nxt;
      busy     <= busy_nxt;
      seq_wrap <= wrap_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mask_tbl[i]  <= 8'h00;
        dwell_tbl[i] <= '0;
      end
    end else if (tbl_we) begin
      if (cfg_sel) begin
        dwell_tbl[cfg_addr] <= dwell_wdata;
      end else begin
        mask_tbl[cfg_addr] <= ui_in;
      end
    end
  end

endmodule

// File: doc/silly_mask_sequencer.md
Name: silly_mask_sequencer

Overview:
Sequencer that drives the 8-bit AND-mask applied to the divided-clock taps. Each table entry holds a mask and a dwell count. The block steps through a DEPTH-entry table of {mask, dwell} pairs and holds each mask on mask_out for a programmed number of clocks. It replaces the static ui_in-to-mask path with a timed, looping pattern. The table is loaded from the input pins while the sequencer is idle.

Parameters:
DEPTH, 4, number of table entries (power of 2, >=2); index width IW = log2(DEPTH)
DWELL_W, 8, width of each entry's dwell counter

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ui_in  input  8  config data (mask value or dwell value)
cfg_we  input  1  table write strobe, sampled on posedge clk
cfg_addr  input  IW  table entry to write
cfg_sel  input  1  0 = write mask[cfg_addr], 1 = write dwell[cfg_addr] (low DWELL_W bits of ui_in; zero-extended if DWELL_W > 8)
run  input  1  level; 1 = sequence, 0 = idle
mask_out  output  8  current mask to the AND stage (registered)
step_idx  output  IW  index of entry currently on mask_out (registered)
busy  output  1  1 while in RUN
seq_wrap  output  1  one-cycle pulse when the sequence wraps back to entry 0

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE; mask_out=0; step_idx=0; busy=0; seq_wrap=0; dwell counter cnt=0.
  - All mask[] and dwell[] entries are cleared to 0.
- Table write:
  - In IDLE, cfg_we=1 writes ui_in into the selected entry on that posedge.
  - In RUN, cfg_we is ignored and the table does not change.
- States: IDLE, RUN. All outputs are registered.
- IDLE:
  - mask_out=0, busy=0, step_idx=0.
  - If run=1 at posedge, go to RUN. On the same edge load mask_out=mask[0], step_idx=0, cnt=dwell[0], busy=1.
  - The first mask is therefore visible one cycle after run is sampled high.
- RUN, each posedge:
  - run=0: go to IDLE; mask_out=0, busy=0, step_idx=0, seq_wrap=0. This has priority over everything else, including an advance due on the same edge.
  - cnt!=0: cnt <= cnt-1; outputs hold.
  - cnt==0: advance. nxt = step_idx+1, wrapping from DEPTH-1 to 0. Load mask_out=mask[nxt], step_idx=nxt, cnt=dwell[nxt].
  - seq_wrap=1 for exactly the cycle in which entry 0 is re-entered by wrap. It is not asserted on the initial entry from IDLE.
- Timing:
  - Entry k is held for dwell[k]+1 cycles; dwell=0 means 1 cycle.
  - One full loop lasts sum over k of (dwell[k]+1) cycles.
- No gaps: there are no bubble cycles between entries.
- The table is sampled at each advance, and writes cannot occur during RUN, so a loaded mask is always consistent.
- Reset asserted mid-run: immediate return to reset values, including clearing the table.
- run toggled 1→0→1: restarts from entry 0 with a fresh dwell[0]; the old position is not resumed.

Test Plan:
1. Reset check: assert rst_n=0 mid-RUN. mask_out=0x00, busy=0, seq_wrap=0 immediately. After release with run=1, mask_out=0x00 for every step (table cleared).
2. Basic sequence: load masks {0x01,0x02,0x04,0x08} and dwells {0,1,2,3}, then set run=1. After 1 cycle mask_out=0x01 for 1 cycle, then 0x02 for 2, 0x04 for 3, 0x08 for 4. Then 0x01 with seq_wrap=1 for that single cycle; the loop period is 10 cycles.
3. Write during RUN: with the sequence running, pulse cfg_we with cfg_addr=1, cfg_sel=0, ui_in=0xFF. The mask for entry 1 stays 0x02 on later loops. After run=0 and a re-write in IDLE, the next run shows 0xFF.
4. Stop/restart: drop run while step_idx=2. Next cycle mask_out=0x00, busy=0. Re-assert run: mask_out=0x01, step_idx=0, seq_wrap=0.
5. Simultaneous events: drop run on the exact edge where cnt==0 for entry 3. Go to IDLE with mask_out=0x00 and no seq_wrap pulse.
6. Max dwell: dwell[0]=0xFF, others 0. Entry 0 is held for 256 cycles, and cnt reloads correctly after the wrap.
